// File: rtl/scramble_sequencer.sv
// Scrambler sequencer: brings the DRBG out of reset, reseeds it every
// RESEED_EVERY frames, and releases the bit consumer and line rotator.
module scramble_sequencer #(
  parameter int INIT_TIMEOUT   = 1024,
  parameter int RESEED_TIMEOUT = 4096,
  parameter int RESEED_EVERY   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        V,
  input  logic        H,
  input  logic        init_ready,
  input  logic        generator_busy,
  input  logic        next_bits_ready,
  input  logic        consumer_need_next,
  output logic        drbg_run,
  output logic        next_seed,
  output logic        next_bits,
  output logic        consumer_run,
  output logic        rotator_run,
  output logic [15:0] frame_count,
  output logic        underrun,
  output logic [7:0]  underrun_count,
  output logic        fault,
  output logic [2:0]  state
);

  localparam int TMO_MAX = (INIT_TIMEOUT > RESEED_TIMEOUT) ? INIT_TIMEOUT : RESEED_TIMEOUT;
  localparam int TW      = $clog2(TMO_MAX + 1);

  localparam logic [TW-1:0] INIT_LAST   = TW'(INIT_TIMEOUT - 1);
  localparam logic [TW-1:0] RESEED_LAST = TW'(RESEED_TIMEOUT - 1);
  localparam logic [7:0]    DIV_LAST    = 8'(RESEED_EVERY - 1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_INIT  = 3'd1,
    ST_WAIT_FRAME = 3'd2,
    ST_RESEED     = 3'd3,
    ST_FILL       = 3'd4,
    ST_RUN        = 3'd5,
    ST_FAULT      = 3'd6
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_v_q;
  logic            r_h_q;
  logic [TW-1:0]   r_tmo;
  logic [7:0]      r_div;
  logic [15:0]     r_frame_count;
  logic [7:0]      r_underrun_count;
  logic            r_underrun;
  logic            r_outstanding;
  logic            r_drbg_run;
  logic            r_next_seed;
  logic            r_consumer_run;
  logic            r_rotator_run;
  logic            r_fault;

  logic            w_v_edge;
  logic            w_h_edge;
  logic            w_frame_tick;
  logic            w_reseed_due;
  logic            w_underrun_hit;
  logic            w_next_bits;

  function automatic logic f_drbg_run(input state_t s);
    return (s == ST_WAIT_INIT) || (s == ST_WAIT_FRAME) || (s == ST_RESEED) ||
           (s == ST_FILL) || (s == ST_RUN);
  endfunction

  function automatic logic f_consumer_run(input state_t s);
    return (s == ST_FILL) || (s == ST_RUN);
  endfunction

  function automatic logic f_timed(input state_t s);
    return (s == ST_WAIT_INIT) || (s == ST_RESEED);
  endfunction

  assign w_v_edge       = V & ~r_v_q;
  assign w_h_edge       = H & ~r_h_q;
  assign w_frame_tick   = (r_state == ST_RUN) && enable && w_v_edge;
  assign w_reseed_due   = w_frame_tick && (r_div == DIV_LAST);
  assign w_underrun_hit = (r_state == ST_RUN) && enable && w_h_edge && r_outstanding;

  // Bits request: held high while filling, follows the consumer while running.
  always_comb begin
    w_next_bits = 1'b0;
    if (r_state == ST_FILL) begin
      w_next_bits = 1'b1;
    end else if (r_state == ST_RUN) begin
      w_next_bits = consumer_need_next;
    end else begin
      w_next_bits = 1'b0;
    end
  end

  // Next-state selection; enable low wins, then timeouts, then ready/busy.
  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_WAIT_INIT;
        ST_WAIT_INIT: begin
          if (r_tmo == INIT_LAST) begin
            w_state_nxt = ST_FAULT;
          end else if (init_ready) begin
            w_state_nxt = ST_WAIT_FRAME;
          end else begin
            w_state_nxt = ST_WAIT_INIT;
          end
        end
        ST_WAIT_FRAME: begin
          if (w_v_edge) begin
            w_state_nxt = ST_RESEED;
          end else begin
            w_state_nxt = ST_WAIT_FRAME;
          end
        end
        // Busy is ignored on the first cycle, while the seed pulse is out.
        ST_RESEED: begin
          if (r_tmo == RESEED_LAST) begin
            w_state_nxt = ST_FAULT;
          end else if ((r_tmo != {TW{1'b0}}) && !generator_busy) begin
            w_state_nxt = ST_FILL;
          end else begin
            w_state_nxt = ST_RESEED;
          end
        end
        ST_FILL: begin
          if (next_bits_ready) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_FILL;
          end
        end
        ST_RUN: begin
          if (w_reseed_due) begin
            w_state_nxt = ST_RESEED;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_FAULT: w_state_nxt = ST_FAULT;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register, edge history, timeout, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_v_q            <= 1'b0;
      r_h_q            <= 1'b0;
      r_tmo            <= {TW{1'b0}};
      r_div            <= 8'd0;
      r_frame_count    <= 16'd0;
      r_underrun_count <= 8'd0;
      r_underrun       <= 1'b0;
      r_outstanding    <= 1'b0;
      r_drbg_run       <= 1'b0;
      r_next_seed      <= 1'b0;
      r_consumer_run   <= 1'b0;
      r_rotator_run    <= 1'b0;
      r_fault          <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_v_q   <= V;
      r_h_q   <= H;

      if ((w_state_nxt != r_state) || !f_timed(r_state)) begin
        r_tmo <= {TW{1'b0}};
      end else begin
        r_tmo <= r_tmo + TW'(1);
      end

      if (w_frame_tick) begin
        r_frame_count <= r_frame_count + 16'd1;
        r_div         <= (r_div == DIV_LAST) ? 8'd0 : r_div + 8'd1;
      end

      // Outstanding only tracks requests made while running.
      if (r_state != ST_RUN) begin
        r_outstanding <= 1'b0;
      end else if (next_bits_ready) begin
        r_outstanding <= 1'b0;
      end else if (w_next_bits) begin
        r_outstanding <= 1'b1;
      end

      r_underrun <= w_underrun_hit;
      if (w_underrun_hit && (r_underrun_count != 8'hFF)) begin
        r_underrun_count <= r_underrun_count + 8'd1;
      end

      r_drbg_run     <= f_drbg_run(w_state_nxt);
      r_next_seed    <= (w_state_nxt == ST_RESEED) && (r_state != ST_RESEED);
      r_consumer_run <= f_consumer_run(w_state_nxt);
      r_rotator_run  <= (w_state_nxt == ST_RUN);
      r_fault        <= (w_state_nxt == ST_FAULT);
    end
  end

  assign drbg_run       = r_drbg_run;
  assign next_seed      = r_next_seed;
  assign next_bits      = w_next_bits;
  assign consumer_run   = r_consumer_run;
  assign rotator_run    = r_rotator_run;
  assign frame_count    = r_frame_count;
  assign underrun       = r_underrun;
  assign underrun_count = r_underrun_count;
  assign fault          = r_fault;
  assign state          = r_state;

endmodule

// File: tb/tb_scramble_sequencer.sv
// Directed-sequence bench for scramble_sequencer with randomized dwell times;
// expectations come from scenario arithmetic (cycle counts, edge tallies).
module tb_scramble_sequencer;
  localparam int INIT_TMO   = 16;
  localparam int RESEED_TMO = 32;
  localparam int EVERY      = 3;

  logic clk = 1'b0;
  logic reset, enable, V, H, init_ready, generator_busy, next_bits_ready, consumer_need_next;
  logic drbg_run, next_seed, next_bits, consumer_run, rotator_run, underrun, fault;
  logic [15:0] frame_count;
  logic [7:0]  underrun_count;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  scramble_sequencer #(
    .INIT_TIMEOUT  (INIT_TMO),
    .RESEED_TIMEOUT(RESEED_TMO),
    .RESEED_EVERY  (EVERY)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .enable            (enable),
    .V                 (V),
    .H                 (H),
    .init_ready        (init_ready),
    .generator_busy    (generator_busy),
    .next_bits_ready   (next_bits_ready),
    .consumer_need_next(consumer_need_next),
    .drbg_run          (drbg_run),
    .next_seed         (next_seed),
    .next_bits         (next_bits),
    .consumer_run      (consumer_run),
    .rotator_run       (rotator_run),
    .frame_count       (frame_count),
    .underrun          (underrun),
    .underrun_count    (underrun_count),
    .fault             (fault),
    .state             (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [2:0] st, input logic dr,
                          input logic cr, input logic rr, input logic ft);
    chk({tag, ".state"}, state, st);
    chk({tag, ".drbg_run"}, drbg_run, dr);
    chk({tag, ".consumer_run"}, consumer_run, cr);
    chk({tag, ".rotator_run"}, rotator_run, rr);
    chk({tag, ".fault"}, fault, ft);
  endtask

  // Starts in the first RESEED cycle; busy held for b cycles, FILL lasts f cycles.
  task automatic reseed_to_run(input int b, input int f);
    int pulses;
    pulses = 0;
    next_bits_ready = 1'b0;
    consumer_need_next = 1'b0;
    chk_outs("reseed_entry", 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i <= b; i++) begin
      chk("reseed.state", state, 3'd3);
      chk("reseed.next_seed", next_seed, (i == 0) ? 1'b1 : 1'b0);
      if (next_seed === 1'b1) pulses++;
      generator_busy = (i < b) ? 1'b1 : 1'b0;
      tick();
    end
    chk("reseed.seed_pulses", pulses, 1);
    generator_busy = 1'b0;
    for (int j = 0; j < f; j++) begin
      chk_outs("fill", 3'd4, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("fill.next_bits", next_bits, 1'b1);
      next_bits_ready = (j == f - 1) ? 1'b1 : 1'b0;
      tick();
    end
    next_bits_ready = 1'b0;
    chk_outs("run_entry", 3'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("run_entry.next_bits", next_bits, 1'b0);
  endtask

  // From IDLE: quick init, then a V edge into RESEED.
  task automatic start_to_reseed();
    enable = 1'b1;
    init_ready = 1'b1;
    tick();
    tick();
    init_ready = 1'b0;
    chk("restart.state", state, 3'd2);
    V = 1'b0;
    tick();
    V = 1'b1;
    tick();
  endtask

  initial begin
    int seeds;
    int gap;
    int ucnt;
    reset = 1'b1; enable = 1'b1; V = 1'b0; H = 1'b0; init_ready = 1'b0;
    generator_busy = 1'b0; next_bits_ready = 1'b0; consumer_need_next = 1'b0;
    tick();
    tick();
    chk_outs("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.frame_count", frame_count, 16'd0);
    chk("reset.underrun_count", underrun_count, 8'd0);
    chk("reset.next_seed", next_seed, 1'b0);
    chk("reset.next_bits", next_bits, 1'b0);
    chk("reset.underrun", underrun, 1'b0);
    enable = 1'b0;
    reset = 1'b0;
    tick();
    chk("idle_hold.state", state, 3'd0);

    // Init handshake: ten cycles in WAIT_INIT.
    enable = 1'b1;
    tick();
    for (int i = 1; i <= 10; i++) begin
      chk_outs("wait_init", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      init_ready = (i == 10) ? 1'b1 : 1'b0;
      tick();
    end
    init_ready = 1'b0;
    chk_outs("wait_frame", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    gap = $urandom_range(1, 5);
    for (int g = 0; g < gap; g++) begin
      tick();
      chk("wait_frame.hold", state, 3'd2);
    end
    V = 1'b1;
    tick();
    reseed_to_run(3, 5);
    chk("first_run.frame_count", frame_count, 16'd0);

    // Six frames with a reseed every third one.
    seeds = 0;
    for (int e = 1; e <= 6; e++) begin
      V = 1'b0;
      gap = $urandom_range(1, 4);
      for (int g = 0; g < gap; g++) begin
        consumer_need_next = 1'($urandom_range(0, 1));
        next_bits_ready = 1'($urandom_range(0, 1));
        #1;
        chk("run.next_bits", next_bits, consumer_need_next);
        chk("run.state", state, 3'd5);
        tick();
      end
      V = 1'b1;
      tick();
      chk("frame.frame_count", frame_count, e);
      if (e % EVERY == 0) begin
        seeds++;
        reseed_to_run($urandom_range(1, 6), $urandom_range(1, 5));
      end else begin
        chk("frame.stay_run", state, 3'd5);
        chk("frame.no_seed", next_seed, 1'b0);
      end
    end
    chk("frames.reseed_entries", seeds, 2);
    chk("frames.frame_count", frame_count, 16'd6);

    // H edge with nothing outstanding must not flag an underrun.
    consumer_need_next = 1'b0;
    next_bits_ready = 1'b1;
    tick();
    next_bits_ready = 1'b0;
    tick();
    H = 1'b1;
    tick();
    chk("no_outstanding.underrun", underrun, 1'b0);
    chk("no_outstanding.count", underrun_count, 8'd0);
    H = 1'b0;
    tick();

    // Starved consumer: every H edge is an underrun, count saturates.
    consumer_need_next = 1'b1;
    tick();
    for (int n = 1; n <= 300; n++) begin
      H = 1'b1;
      tick();
      ucnt = (n > 255) ? 255 : n;
      chk("starve.underrun", underrun, 1'b1);
      chk("starve.count", underrun_count, ucnt);
      H = 1'b0;
      tick();
      chk("starve.pulse_end", underrun, 1'b0);
    end
    next_bits_ready = 1'b1;
    tick();
    consumer_need_next = 1'b0;
    next_bits_ready = 1'b0;
    tick();
    H = 1'b1;
    tick();
    chk("ready_cleared.underrun", underrun, 1'b0);
    H = 1'b0;
    tick();

    // enable low together with a V edge in RUN.
    V = 1'b0;
    tick();
    V = 1'b1;
    enable = 1'b0;
    tick();
    chk_outs("disable_run", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("disable_run.next_seed", next_seed, 1'b0);
    chk("disable_run.frame_count", frame_count, 16'd6);
    chk("disable_run.underrun_count", underrun_count, 8'd255);
    tick();
    chk("disable_run.idle", state, 3'd0);

    // Init timeout with init_ready never asserted.
    enable = 1'b1;
    tick();
    for (int i = 1; i <= INIT_TMO; i++) begin
      chk_outs("init_tmo.wait", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    chk_outs("init_tmo.fault", 3'd6, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("init_tmo.next_bits", next_bits, 1'b0);
    init_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fault.sticky", state, 3'd6);
    end
    init_ready = 1'b0;
    enable = 1'b0;
    tick();
    chk_outs("fault_exit", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Timeout beats init_ready arriving on the last allowed cycle.
    enable = 1'b1;
    tick();
    for (int i = 1; i <= INIT_TMO; i++) begin
      init_ready = (i == INIT_TMO) ? 1'b1 : 1'b0;
      tick();
    end
    init_ready = 1'b0;
    chk("init_tmo_prio.state", state, 3'd6);
    enable = 1'b0;
    tick();

    // Reseed timeout; busy drops on the final cycle but timeout wins.
    start_to_reseed();
    generator_busy = 1'b1;
    for (int i = 0; i < RESEED_TMO; i++) begin
      chk("reseed_tmo.wait", state, 3'd3);
      generator_busy = (i == RESEED_TMO - 1) ? 1'b0 : 1'b1;
      tick();
    end
    chk_outs("reseed_tmo.fault", 3'd6, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("reseed_tmo.frame_count", frame_count, 16'd6);
    enable = 1'b0;
    generator_busy = 1'b0;
    tick();

    // Reset in the middle of RUN overrides enable.
    start_to_reseed();
    reseed_to_run($urandom_range(1, 6), $urandom_range(1, 5));
    chk("pre_reset.underrun_count", underrun_count, 8'd255);
    reset = 1'b1;
    tick();
    chk_outs("reset_run", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_run.frame_count", frame_count, 16'd0);
    chk("reset_run.underrun_count", underrun_count, 8'd0);
    reset = 1'b0;
    tick();
    chk("post_reset.state", state, 3'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
